// File: rtl/fetch_unit.sv
// Instruction fetch unit: a three-state IDLE/FETCH/FULL controller that fetches one word
// at a time into a single instruction register and accepts redirects from execute.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        pc_load,
  input  logic [31:0] pc_target,
  input  logic        ir_ready,
  output logic [31:0] ir,
  output logic [31:0] ir_pc,
  output logic        ir_valid,
  output logic [31:0] fetch_cnt,
  output logic        misalign
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;

  // Redirect targets are forced onto a word boundary; the low bits only feed misalign.
  function automatic logic [31:0] align_target(input logic [31:0] t);
    return {t[31:2], 2'b00};
  endfunction

  // Sequential address and delivery count both wrap silently at 2^32.
  function automatic logic [31:0] wrap_add(input logic [31:0] a, input logic [31:0] b);
    return a + b;
  endfunction

  assign imem_req  = (state == FETCH);
  assign imem_addr = pc;

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      ir        <= 32'h0;
      ir_pc     <= 32'h0;
      ir_valid  <= 1'b0;
      fetch_cnt <= 32'h0;
      misalign  <= 1'b0;
    end else begin
      // A redirect overrides ack and consume in every state, discarding same-cycle data.
      if (pc_load) begin
        pc       <= align_target(pc_target);
        ir_valid <= 1'b0;
        state    <= FETCH;
        if (pc_target[1:0] != 2'b00) misalign <= 1'b1;
      end else begin
        case (state)
          IDLE: state <= FETCH;
          FETCH: begin
            if (imem_ack) begin
              ir        <= imem_rdata;
              ir_pc     <= pc;
              ir_valid  <= 1'b1;
              pc        <= wrap_add(pc, 32'd4);
              fetch_cnt <= wrap_add(fetch_cnt, 32'd1);
              state     <= FULL;
            end
          end
          FULL: begin
            if (ir_ready) begin
              ir_valid <= 1'b0;
              state    <= FETCH;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: one instance at the default reset PC and one at 0xFFFF_FFFC.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rstn;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        pc_load;
  logic [31:0] pc_target;
  logic        ir_ready;

  logic        imem_req, d2_req;
  logic [31:0] imem_addr, d2_addr;
  logic [31:0] ir, d2_ir;
  logic [31:0] ir_pc, d2_ir_pc;
  logic        ir_valid, d2_ir_valid;
  logic [31:0] fetch_cnt, d2_cnt;
  logic        misalign, d2_mis;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .rstn(rstn), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .pc_load(pc_load),
    .pc_target(pc_target), .ir_ready(ir_ready), .ir(ir), .ir_pc(ir_pc),
    .ir_valid(ir_valid), .fetch_cnt(fetch_cnt), .misalign(misalign)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_hi (
    .clk(clk), .rstn(rstn), .imem_req(d2_req), .imem_addr(d2_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .pc_load(pc_load),
    .pc_target(pc_target), .ir_ready(ir_ready), .ir(d2_ir), .ir_pc(d2_ir_pc),
    .ir_valid(d2_ir_valid), .fetch_cnt(d2_cnt), .misalign(d2_mis)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b1; imem_ack = 1'b0; pc_load = 1'b0; ir_ready = 1'b0;
    imem_rdata = 32'h0; pc_target = 32'h0;
    tick(); tick();
    rstn = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rstn = 1'b1; imem_ack = 1'b0; pc_load = 1'b0; ir_ready = 1'b0;
    imem_rdata = 32'h0; pc_target = 32'h0;
    tick(); tick();
    n_vec++; if (imem_req !== 1'b0) begin $display("FAIL rst_req got %b want 0", imem_req); n_err++; end
    n_vec++; if (imem_addr !== 32'h0) begin $display("FAIL rst_addr got %h want 00000000", imem_addr); n_err++; end
    n_vec++; if (ir !== 32'h0 || ir_pc !== 32'h0) begin $display("FAIL rst_ir got %h/%h want 0/0", ir, ir_pc); n_err++; end
    n_vec++; if (ir_valid !== 1'b0 || misalign !== 1'b0) begin $display("FAIL rst_flags got v=%b m=%b want 0/0", ir_valid, misalign); n_err++; end
    n_vec++; if (fetch_cnt !== 32'h0) begin $display("FAIL rst_cnt got %0d want 0", fetch_cnt); n_err++; end
    n_vec++; if (d2_addr !== 32'hFFFF_FFFC) begin $display("FAIL rst_addr_hi got %h want fffffffc", d2_addr); n_err++; end
    // Release with a stray ack present while still in IDLE.
    rstn = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
    n_vec++; if (imem_req !== 1'b0) begin $display("FAIL idle_req got %b want 0", imem_req); n_err++; end
    tick();
    imem_ack = 1'b0;
    n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin $display("FAIL first_req got %b@%h want 1@00000000", imem_req, imem_addr); n_err++; end
    n_vec++; if (fetch_cnt !== 32'h0 || ir_valid !== 1'b0) begin $display("FAIL idle_ack_ignored got cnt=%0d v=%b want 0/0", fetch_cnt, ir_valid); n_err++; end
  endtask

  task automatic test_stream();
    ir_ready = 1'b1; imem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      imem_rdata = 32'hA000_0000 + 32'(4 * i);
      n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'(4 * i)) begin $display("FAIL stream_req[%0d] got %b@%h want 1@%h", i, imem_req, imem_addr, 32'(4 * i)); n_err++; end
      tick();
      n_vec++; if (ir_valid !== 1'b1 || imem_req !== 1'b0) begin $display("FAIL stream_full[%0d] got v=%b req=%b want 1/0", i, ir_valid, imem_req); n_err++; end
      n_vec++; if (ir !== 32'hA000_0000 + 32'(4 * i) || ir_pc !== 32'(4 * i)) begin $display("FAIL stream_ir[%0d] got %h@%h want %h@%h", i, ir, ir_pc, 32'hA000_0000 + 32'(4 * i), 32'(4 * i)); n_err++; end
      n_vec++; if (fetch_cnt !== 32'(i + 1)) begin $display("FAIL stream_cnt[%0d] got %0d want %0d", i, fetch_cnt, i + 1); n_err++; end
      tick();
      n_vec++; if (ir_valid !== 1'b0) begin $display("FAIL stream_consume[%0d] got %b want 0", i, ir_valid); n_err++; end
    end
    imem_ack = 1'b0; ir_ready = 1'b0;
  endtask

  task automatic test_wait();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      imem_ack = (i == 3);
      imem_rdata = (i == 3) ? 32'h1234_5678 : 32'hDEAD_0000;
      n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin $display("FAIL wait_hold[%0d] got %b@%h want 1@00000000", i, imem_req, imem_addr); n_err++; end
      tick();
    end
    imem_ack = 1'b0;
    n_vec++; if (ir !== 32'h1234_5678 || ir_pc !== 32'h0 || ir_valid !== 1'b1) begin $display("FAIL wait_ir got %h@%h v=%b want 12345678@00000000 v=1", ir, ir_pc, ir_valid); n_err++; end
    n_vec++; if (fetch_cnt !== 32'd1) begin $display("FAIL wait_cnt got %0d want 1", fetch_cnt); n_err++; end
  endtask

  task automatic test_stall();
    ir_ready = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hFFFF_0000;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_vec++; if (ir !== 32'h1234_5678 || ir_pc !== 32'h0 || ir_valid !== 1'b1 || imem_req !== 1'b0) begin $display("FAIL stall[%0d] got %h@%h v=%b req=%b want 12345678@00000000 v=1 req=0", i, ir, ir_pc, ir_valid, imem_req); n_err++; end
    end
    imem_ack = 1'b0; ir_ready = 1'b1;
    tick();
    ir_ready = 1'b0;
    n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h4 || ir_valid !== 1'b0) begin $display("FAIL stall_release got %b@%h v=%b want 1@00000004 v=0", imem_req, imem_addr, ir_valid); n_err++; end
  endtask

  task automatic test_redirect();
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; pc_load = 1'b1; pc_target = 32'h100;
    tick();
    pc_load = 1'b0; imem_ack = 1'b0;
    n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin $display("FAIL redir_addr got %b@%h want 1@00000100", imem_req, imem_addr); n_err++; end
    n_vec++; if (fetch_cnt !== 32'd1 || ir_valid !== 1'b0 || ir !== 32'h1234_5678) begin $display("FAIL redir_discard got cnt=%0d v=%b ir=%h want 1/0/12345678", fetch_cnt, ir_valid, ir); n_err++; end
    n_vec++; if (misalign !== 1'b0) begin $display("FAIL redir_aligned got %b want 0", misalign); n_err++; end
    imem_ack = 1'b1; imem_rdata = 32'h0000_0100;
    tick();
    imem_ack = 1'b0;
    n_vec++; if (ir_pc !== 32'h100 || fetch_cnt !== 32'd2) begin $display("FAIL redir_fetch got %h cnt=%0d want 00000100 cnt=2", ir_pc, fetch_cnt); n_err++; end
    // Misaligned redirect from FULL, competing with a consume.
    pc_load = 1'b1; pc_target = 32'h102; ir_ready = 1'b1;
    tick();
    pc_load = 1'b0; ir_ready = 1'b0;
    n_vec++; if (misalign !== 1'b1 || imem_addr !== 32'h100 || imem_req !== 1'b1) begin $display("FAIL misalign got m=%b %b@%h want m=1 1@00000100", misalign, imem_req, imem_addr); n_err++; end
    n_vec++; if (ir_valid !== 1'b0 || fetch_cnt !== 32'd2) begin $display("FAIL misalign_full got v=%b cnt=%0d want 0/2", ir_valid, fetch_cnt); n_err++; end
    imem_ack = 1'b1; imem_rdata = 32'h0000_0200;
    tick();
    imem_ack = 1'b0;
    n_vec++; if (misalign !== 1'b1 || fetch_cnt !== 32'd3 || ir !== 32'h0000_0200) begin $display("FAIL misalign_sticky got m=%b cnt=%0d ir=%h want 1/3/00000200", misalign, fetch_cnt, ir); n_err++; end
  endtask

  task automatic test_wrap_reset();
    do_reset();
    n_vec++; if (d2_req !== 1'b1 || d2_addr !== 32'hFFFF_FFFC) begin $display("FAIL wrap_first got %b@%h want 1@fffffffc", d2_req, d2_addr); n_err++; end
    imem_ack = 1'b1; imem_rdata = 32'hCAFE_0001; ir_ready = 1'b1;
    tick();
    imem_ack = 1'b0;
    n_vec++; if (d2_ir_pc !== 32'hFFFF_FFFC || d2_ir !== 32'hCAFE_0001 || d2_cnt !== 32'd1) begin $display("FAIL wrap_deliver got %h@%h cnt=%0d want cafe0001@fffffffc cnt=1", d2_ir, d2_ir_pc, d2_cnt); n_err++; end
    tick();
    ir_ready = 1'b0;
    n_vec++; if (d2_req !== 1'b1 || d2_addr !== 32'h0) begin $display("FAIL wrap_addr got %b@%h want 1@00000000", d2_req, d2_addr); n_err++; end
    tick();
    rstn = 1'b1;
    #1;
    n_vec++; if (d2_req !== 1'b0 || imem_req !== 1'b0) begin $display("FAIL async_rst_req got %b/%b want 0/0", d2_req, imem_req); n_err++; end
    n_vec++; if (d2_addr !== 32'hFFFF_FFFC || d2_ir !== 32'h0 || d2_ir_pc !== 32'h0) begin $display("FAIL async_rst_regs got %h %h %h want fffffffc 0 0", d2_addr, d2_ir, d2_ir_pc); n_err++; end
    n_vec++; if (d2_ir_valid !== 1'b0 || d2_cnt !== 32'h0 || d2_mis !== 1'b0) begin $display("FAIL async_rst_flags got v=%b cnt=%0d m=%b want 0/0/0", d2_ir_valid, d2_cnt, d2_mis); n_err++; end
    n_vec++; if (misalign !== 1'b0 || fetch_cnt !== 32'h0) begin $display("FAIL async_rst_dut0 got m=%b cnt=%0d want 0/0", misalign, fetch_cnt); n_err++; end
    tick();
    rstn = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_wait();
    test_stall();
    test_redirect();
    test_wrap_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
